// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller: FSM encodings,
// legal width range and the bit-counter sizing helper.
package sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Counter only has to reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= WIDTH_MIN) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor (x - y - z) assembled from the basic XOR/NOT gate
// cells plus AND/OR terms for the borrow.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module not_gate (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic nb
);
  logic x_xor_y;
  logic x_n;

  xor_gate u_xor_xy (.a(x),       .b(y), .y(x_xor_y));
  xor_gate u_xor_z  (.a(x_xor_y), .b(z), .y(d));
  not_gate u_not_x  (.a(x),       .y(x_n));

  // Borrow whenever the subtrahend side (y, z) outweighs x.
  assign nb = (x_n & y) | (x_n & z) | (y & z);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell is stepped LSB-first
// over WIDTH cycles; diff/bout are held from the done pulse until the next start.
module serial_subtractor_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       state_dbg
);

  // Handshake: a request is accepted on a rising edge where start=1 and
  // ready=1 (IDLE only); start at any other time is dropped, never queued.
  // done pulses for one cycle when diff/bout become final.

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             cell_d;
  logic             cell_nb;
  logic             accept;
  logic             shifting;

  assign accept   = (state == ST_IDLE) && start;
  assign shifting = (state == ST_SHIFT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; the unused code 2'b11 falls back to IDLE.
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:  state_nx = start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_nx = (cnt == CNT_LAST) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_IDLE:  ready = 1'b1;
      ST_SHIFT: busy  = 1'b1;
      ST_DONE:  done  = 1'b1;
      default: begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  full_subtractor_cell u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .z  (borrow),
    .d  (cell_d),
    .nb (cell_nb)
  );

  // Datapath: load on accept, step the cell once per SHIFT cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      borrow  <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      diff_sr <= '0;
      cnt     <= '0;
      borrow  <= bin;
    end else if (shifting) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
      cnt     <= cnt + 1'b1;
      borrow  <= cell_nb;
    end
  end

  assign diff      = diff_sr;
  assign bout      = borrow;
  assign state_dbg = state;

endmodule
